// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg: shared Wishbone width defaults, state type
// and a log2 helper for the arbiter slice.
package wb_rr_arbiter_pkg;

    localparam int WB_DW      = 32;
    localparam int WB_AW      = 32;
    localparam int WB_SW      = WB_DW / 8;
    localparam int WB_TIMEOUT = 255;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_e;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick: rotate-and-priority round-robin picker.
// First requester strictly after the pointer wins (mod NM).
module rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NM = 2,
    parameter int PW = 1
) (
    input  logic [NM-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NM-1:0] o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    int w_k;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = 0;
        for (int i = 1; i <= NM; i++) begin
            w_k = (int'(i_ptr) + i) % NM;
            if (!o_any && i_req[w_k]) begin
                o_any      = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = PW'(w_k);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master to 1-slave Wishbone classic arbiter with
// round-robin grant held per CYC and a per-transfer watchdog.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NM           = 2,
    parameter int DATA_WIDTH   = WB_DW,
    parameter int ADDR_WIDTH   = WB_AW,
    parameter int SELECT_WIDTH = WB_SW,
    parameter int TIMEOUT      = WB_TIMEOUT
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic [NM*ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [NM*DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]      wbm_dat_o,
    input  logic [NM-1:0]              wbm_we_i,
    input  logic [NM*SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic [NM-1:0]              wbm_stb_i,
    input  logic [NM-1:0]              wbm_cyc_i,
    output logic [NM-1:0]              wbm_ack_o,
    output logic [NM-1:0]              wbm_err_o,
    output logic [ADDR_WIDTH-1:0]      wbs_adr_o,
    output logic [DATA_WIDTH-1:0]      wbs_dat_o,
    output logic                       wbs_we_o,
    output logic [SELECT_WIDTH-1:0]    wbs_sel_o,
    output logic                       wbs_stb_o,
    output logic                       wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]      wbs_dat_i,
    input  logic                       wbs_ack_i,
    input  logic                       wbs_err_i,
    output logic [NM-1:0]              grant_o
);

    localparam int PW = clog2_min1(NM);
    localparam int CW = clog2_min1(TIMEOUT + 1);
    localparam logic [PW-1:0] PTR_RST = PW'(NM - 1);

    arb_state_e    r_state;
    arb_state_e    w_state_nx;
    logic [NM-1:0] r_grant;
    logic [NM-1:0] w_grant_nx;
    logic [PW-1:0] r_idx;
    logic [PW-1:0] w_idx_nx;
    logic [CW-1:0] r_cnt;

    logic [NM-1:0] w_pick;
    logic [PW-1:0] w_pick_idx;
    logic          w_any;
    logic [PW-1:0] w_sel;
    logic          w_own;
    logic          w_cyc;
    logic          w_stb;
    logic          w_rsp;
    logic          w_tmo;
    logic          w_wait;

    rr_pick #(
        .NM (NM),
        .PW (PW)
    ) u_pick (
        .i_req (wbm_cyc_i),
        .i_ptr (r_idx),
        .o_gnt (w_pick),
        .o_idx (w_pick_idx),
        .o_any (w_any)
    );

    // r_idx is both the owner index and the round-robin pointer
    assign w_own  = (r_state == ST_GRANT);
    assign w_sel  = w_own ? r_idx : '0;
    assign w_cyc  = w_own & wbm_cyc_i[w_sel];
    assign w_stb  = w_cyc & wbm_stb_i[w_sel];
    assign w_rsp  = wbs_ack_i | wbs_err_i;
    assign w_tmo  = (TIMEOUT != 0) && w_stb && !w_rsp
                    && (r_cnt == CW'(TIMEOUT - 1));
    assign w_wait = (TIMEOUT != 0) && w_stb && !w_rsp && !w_tmo;

    assign wbs_adr_o = wbm_adr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wbs_dat_o = wbm_dat_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign wbs_sel_o = wbm_sel_i[int'(w_sel)*SELECT_WIDTH +: SELECT_WIDTH];
    assign wbs_we_o  = wbm_we_i[w_sel];
    assign wbs_cyc_o = w_cyc;
    assign wbs_stb_o = w_stb;
    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = r_grant;

    // responses are gated so a late ack after CYC drop is dropped
    assign wbm_ack_o = (w_stb && wbs_ack_i) ? r_grant : '0;
    assign wbm_err_o = ((w_stb && wbs_err_i) || w_tmo) ? r_grant : '0;

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_idx_nx   = r_idx;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nx = ST_GRANT;
                    w_grant_nx = w_pick;
                    w_idx_nx   = w_pick_idx;
                end
            end
            ST_GRANT: begin
                if (!wbm_cyc_i[r_idx]) begin
                    w_state_nx = ST_IDLE;
                    w_grant_nx = '0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= PTR_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_wait ? r_cnt + CW'(1) : '0;
        end
    end

endmodule
